// File: rtl/coef_pack48.sv
// coef_pack48: splits each 48-bit group of four 12-bit coefficients into six
// little-endian bytes (ByteEncode12 order), flagging the last byte of every polynomial.
// Optional range check on accepted words: define COEF_PACK48_RANGE_CHK_EN.
module coef_pack48 #(
    parameter int IWID  = 12,
    parameter int NWORD = 64,
    parameter int QMOD  = 3329
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*IWID-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic [7:0]        dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              dout_last,
    output logic              err
);

    localparam int WW  = 4 * IWID;
    localparam int WCW = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(NWORD - 1);

    logic [WW-1:0]  act_q, act_n;
    logic [WW-1:0]  hold_q, hold_n;
    logic           act_full_q, act_full_n;
    logic           hold_full_q, hold_full_n;
    logic [2:0]     bcnt_q, bcnt_n;
    logic [WCW-1:0] wcnt_q, wcnt_n;
    logic           last_q, last_n;

    logic acc;
    logic xfer;
    logic retire;

    assign acc    = din_vld && !hold_full_q;
    assign xfer   = act_full_q && dout_rdy;
    assign retire = xfer && (bcnt_q == 3'd5);

    always_comb begin
        act_n       = act_q;
        hold_n      = hold_q;
        act_full_n  = act_full_q;
        hold_full_n = hold_full_q;
        bcnt_n      = bcnt_q;
        wcnt_n      = wcnt_q;

        // Active word is kept as a shift register so dout is always its low byte.
        if (xfer && !retire) begin
            bcnt_n = bcnt_q + 3'd1;
            act_n  = act_q >> 8;
        end else if (retire) begin
            wcnt_n = (wcnt_q == WLAST) ? '0 : wcnt_q + 1'b1;
            bcnt_n = 3'd0;
            if (hold_full_q) begin
                act_n       = hold_q;
                hold_full_n = 1'b0;
            end else if (acc) begin
                act_n = din;
            end else begin
                act_full_n = 1'b0;
            end
        end

        if (acc && !retire) begin
            if (!act_full_q) begin
                act_n      = din;
                act_full_n = 1'b1;
                bcnt_n     = 3'd0;
            end else begin
                hold_n      = din;
                hold_full_n = 1'b1;
            end
        end

        last_n = act_full_n && (bcnt_n == 3'd5) && (wcnt_n == WLAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q       <= '0;
            hold_q      <= '0;
            act_full_q  <= 1'b0;
            hold_full_q <= 1'b0;
            bcnt_q      <= 3'd0;
            wcnt_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            act_q       <= act_n;
            hold_q      <= hold_n;
            act_full_q  <= act_full_n;
            hold_full_q <= hold_full_n;
            bcnt_q      <= bcnt_n;
            wcnt_q      <= wcnt_n;
            last_q      <= last_n;
        end
    end

    assign din_rdy   = !hold_full_q;
    assign dout      = act_q[7:0];
    assign dout_vld  = act_full_q;
    assign dout_last = last_q;

`ifdef COEF_PACK48_RANGE_CHK_EN
    logic err_q;
    logic oor;

    always_comb begin
        oor = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int'(din[i*IWID +: IWID]) >= QMOD) oor = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (acc && oor) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_coef_pack48.sv
// Bench for coef_pack48: fixed vectors, hand-built corner sequences and random
// traffic, all checked against a byte-queue model of the packer.
module tb_coef_pack48;

    logic        clk;
    logic        rst;
    logic [47:0] din;
    logic        din_vld;
    logic        din_rdy;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic        dout_last;
    logic        err;

    coef_pack48 dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout_last (dout_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: bytes still owed downstream, and how many have left so far.
    logic [7:0] q[$];
    int         delivered;
    logic       err_m;

    // Values seen by the most recent cyc() call.
    logic       s_vld, s_acc, s_last, s_rdy;
    logic [7:0] s_dout;

    typedef struct {
        logic [47:0] w;
        logic [7:0]  b[6];
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void push_word(input logic [47:0] w);
        logic [11:0] c0, c1, c2, c3;
        c0 = w[11:0];
        c1 = w[23:12];
        c2 = w[35:24];
        c3 = w[47:36];
        q.push_back(c0[7:0]);
        q.push_back({c1[3:0], c0[11:8]});
        q.push_back(c1[11:4]);
        q.push_back(c2[7:0]);
        q.push_back({c3[3:0], c2[11:8]});
        q.push_back(c3[11:4]);
`ifdef COEF_PACK48_RANGE_CHK_EN
        if (c0 >= 12'd3329 || c1 >= 12'd3329 || c2 >= 12'd3329 || c3 >= 12'd3329)
            err_m = 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        q.delete();
        delivered = 0;
        err_m     = 1'b0;
    endfunction

    // One clock: drive at the falling edge, check registered outputs, advance the model.
    task automatic cyc(input logic v, input logic [47:0] d, input logic r);
        logic acc, xfer;
        din_vld  = v;
        din      = d;
        dout_rdy = r;
        #1;
        chk("dout_vld", {7'd0, dout_vld}, {7'd0, q.size() > 0});
        chk("din_rdy", {7'd0, din_rdy}, {7'd0, q.size() <= 6});
        chk("err", {7'd0, err}, {7'd0, err_m});
        if (q.size() > 0) begin
            chk("dout", dout, q[0]);
            chk("dout_last", {7'd0, dout_last}, {7'd0, (delivered % 384) == 383});
        end else begin
            chk("dout_last_idle", {7'd0, dout_last}, 8'd0);
        end
        acc    = v && (q.size() <= 6);
        xfer   = (q.size() > 0) && r;
        s_vld  = dout_vld;
        s_dout = dout;
        s_last = dout_last;
        s_rdy  = din_rdy;
        s_acc  = acc;
        if (xfer) begin
            void'(q.pop_front());
            delivered++;
        end
        if (acc) push_word(d);
        @(negedge clk);
    endtask

    initial begin
        int got, first_c, last_c, idx, lasts;
        logic seen_full;
        logic [47:0] bw[3];

        tv[0].w = 48'h123456789ABC; tv[0].b = '{8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
        tv[1].w = 48'h0000000000FF; tv[1].b = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv[2].w = 48'hFFF000000000; tv[2].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hFF};
        tv[3].w = 48'hABCDEF012345; tv[3].b = '{8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB};
        tv[4].w = 48'h000000000D01; tv[4].b = '{8'h01, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};

        rst = 1'b0; din = '0; din_vld = 1'b0; dout_rdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dout_vld", {7'd0, dout_vld}, 8'd0);
        chk("rst_dout", dout, 8'd0);
        chk("rst_dout_last", {7'd0, dout_last}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_din_rdy", {7'd0, din_rdy}, 8'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single words through an idle block.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, tv[i].w, 1'b1);
            chk("tbl_accept", {7'd0, s_acc}, 8'd1);
            got = 0;
            for (int c = 0; c < 12 && got < 6; c++) begin
                cyc(1'b0, '0, 1'b1);
                if (s_vld) begin
                    chk("tbl_byte", s_dout, tv[i].b[got]);
                    got++;
                end
            end
            chk("tbl_count", 8'(got), 8'd6);
            cyc(1'b0, '0, 1'b1);
        end
`ifdef COEF_PACK48_RANGE_CHK_EN
        chk("err_sticky", {7'd0, err}, 8'd1);
`else
        chk("err_sticky", {7'd0, err}, 8'd0);
`endif

        // Back-to-back words: 12 bytes with no gap.
        bw[0] = 48'h0000000000FF; bw[1] = 48'hFFF000000000;
        idx = 0; got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 20; c++) begin
            cyc(idx < 2, (idx < 2) ? bw[idx] : 48'h0, 1'b1);
            if (s_acc) idx++;
            if (s_vld) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
        end
        chk("b2b_count", 8'(got), 8'd12);
        chk("b2b_span", 8'(last_c - first_c), 8'd11);

        // Backpressure 1,0,0,1 with three words offered continuously.
        bw[0] = 48'h111222333444; bw[1] = 48'h555666777888; bw[2] = 48'h999AAABBBCCC;
        idx = 0; seen_full = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cyc(idx < 3, (idx < 3) ? bw[idx] : 48'h0, (c % 4 == 0) || (c % 4 == 3));
            if (s_acc) idx++;
            if (idx == 2 && !s_rdy) seen_full = 1'b1;
        end
        chk("bp_refused", {7'd0, seen_full}, 8'd1);
        chk("bp_all_taken", 8'(idx), 8'd3);

        // Asynchronous reset after byte 2 with a word waiting in hold.
        cyc(1'b1, 48'hCAFEBABE1234, 1'b1);
        cyc(1'b1, 48'h0BADF00D5678, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_dout_vld", {7'd0, dout_vld}, 8'd0);
        chk("arst_din_rdy", {7'd0, din_rdy}, 8'd1);
        chk("arst_dout_last", {7'd0, dout_last}, 8'd0);
        chk("arst_err", {7'd0, err}, 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Two polynomials back to back: dout_last on bytes 384 and 768 only.
        idx = 0; lasts = 0;
        for (int c = 0; c < 128 * 6 + 20; c++) begin
            cyc(idx < 128, {$urandom, $urandom} & 48'h7FF7FF7FF7FF, 1'b1);
            if (s_acc) idx++;
            if (s_vld && s_last) lasts++;
        end
        chk("poly_words", 8'(idx), 8'd128);
        chk("poly_lasts", 8'(lasts), 8'd2);

        // Random traffic, including out-of-range coefficients.
        for (int c = 0; c < 3000; c++) begin
            logic [47:0] w;
            w = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) w = w & 48'h7FF7FF7FF7FF;
            cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0);
        end
        for (int c = 0; c < 20; c++) cyc(1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
